// File: rtl/cmm_adder_arbiter_if.sv
// Bus bundle between two matrix requesters, the shared adder and the arbiter.
// The arbiter takes the slave view; the requesters/adder side takes master.
interface cmm_adder_arbiter_if #(
   parameter int DW = 256
);
   logic          req0_valid;
   logic          req0_ready;
   logic [DW-1:0] req0_a;
   logic [DW-1:0] req0_b;
   logic          req1_valid;
   logic          req1_ready;
   logic [DW-1:0] req1_a;
   logic [DW-1:0] req1_b;
   logic          resp0_valid;
   logic          resp0_ready;
   logic [DW-1:0] resp0_data;
   logic          resp1_valid;
   logic          resp1_ready;
   logic [DW-1:0] resp1_data;
   logic [DW-1:0] add_a;
   logic [DW-1:0] add_b;
   logic          add_in_valid;
   logic          add_in_ready;
   logic [DW-1:0] add_out_data;
   logic          add_out_valid;
   logic          add_out_ready;
   logic          err;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  resp0_ready, resp1_ready,
      input  add_in_ready, add_out_data, add_out_valid,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_data,
      output resp1_valid, resp1_data,
      output add_a, add_b, add_in_valid, add_out_ready,
      output err
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output resp0_ready, resp1_ready,
      output add_in_ready, add_out_data, add_out_valid,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_data,
      input  resp1_valid, resp1_data,
      input  add_a, add_b, add_in_valid, add_out_ready,
      input  err
   );
endinterface

// File: rtl/cmm_adder_arbiter.sv
// Round-robin arbiter sharing one matrix adder between two requesters.
// Define CMM_ARB_TIMEOUT_EN to enable the result watchdog and err pulse.
module cmm_adder_arbiter #(
   parameter int MAT_WIDTH      = 4,
   parameter int MAT_HEIGHT     = 4,
   parameter int ELEMENT_SIZE   = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                clk,
   input logic                reset_n,
   cmm_adder_arbiter_if.slave bus
);
   localparam int DW = MAT_WIDTH * MAT_HEIGHT * ELEMENT_SIZE;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;
   logic          owner_q, owner_d;
   logic [DW-1:0] add_a_q, add_a_d;
   logic [DW-1:0] add_b_q, add_b_d;
   logic [DW-1:0] resp0_q, resp0_d;
   logic [DW-1:0] resp1_q, resp1_d;
   logic          any_req;
   logic          grant;
   logic          resp_hs;
   logic          expire;

   always_comb begin
      any_req = bus.req0_valid | bus.req1_valid;
      grant   = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
      resp_hs = owner_q ? bus.resp1_ready : bus.resp0_ready;
   end

`ifdef CMM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count WAIT cycles without a result; cleared on the way into WAIT.
   always_comb begin
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (state_q == ISSUE) begin
         cnt_d = '0;
      end else if (state_q == WAIT && !bus.add_out_valid) begin
         cnt_d  = cnt_q + 1'b1;
         expire = (cnt_d == CW'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      add_a_d = add_a_q;
      add_b_d = add_b_q;
      resp0_d = resp0_q;
      resp1_d = resp1_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = ISSUE;
               owner_d = grant;
               rr_d    = ~grant;
               add_a_d = grant ? bus.req1_a : bus.req0_a;
               add_b_d = grant ? bus.req1_b : bus.req0_b;
            end
         end
         ISSUE: begin
            if (bus.add_in_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.add_out_valid) begin
               state_d = RESP;
               if (owner_q) resp1_d = bus.add_out_data;
               else         resp0_d = bus.add_out_data;
            end else if (expire) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (resp_hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         owner_q <= 1'b0;
         add_a_q <= '0;
         add_b_q <= '0;
         resp0_q <= '0;
         resp1_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         add_a_q <= add_a_d;
         add_b_q <= add_b_d;
         resp0_q <= resp0_d;
         resp1_q <= resp1_d;
      end
   end

   // Ready is gated by reset so a held valid cannot show through reset.
   assign bus.req0_ready    = reset_n & (state_q == IDLE) & any_req & ~grant;
   assign bus.req1_ready    = reset_n & (state_q == IDLE) & grant;
   assign bus.add_in_valid  = (state_q == ISSUE);
   assign bus.add_out_ready = (state_q == WAIT);
   assign bus.resp0_valid   = (state_q == RESP) & ~owner_q;
   assign bus.resp1_valid   = (state_q == RESP) & owner_q;
   assign bus.resp0_data    = resp0_q;
   assign bus.resp1_data    = resp1_q;
   assign bus.add_a         = add_a_q;
   assign bus.add_b         = add_b_q;
   assign bus.err           = expire;
endmodule

// File: tb/tb_cmm_adder_arbiter.sv
// Randomized bench for cmm_adder_arbiter against a transaction-level model.
// Acts as both requesters and the shared adder.
module tb_cmm_adder_arbiter;
   localparam int MW  = 4;
   localparam int MH  = 4;
   localparam int ES  = 16;
   localparam int DW  = MW * MH * ES;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cmm_adder_arbiter_if #(.DW(DW)) bus ();

   cmm_adder_arbiter #(
      .MAT_WIDTH(MW),
      .MAT_HEIGHT(MH),
      .ELEMENT_SIZE(ES),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Model: pending requests, their operands, and the fairness pointer.
   bit            pend [2];
   logic [DW-1:0] pa   [2];
   logic [DW-1:0] pb   [2];
   bit            mdl_rr;
   bit            spawn_en;
   logic [DW-1:0] last_resp;

   function automatic logic [DW-1:0] elem_sum(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
      logic [DW-1:0] s;
      s = '0;
      for (int i = 0; i < MW * MH; i++)
         s[i*ES +: ES] = a[i*ES +: ES] + b[i*ES +: ES];
      return s;
   endfunction

   function automatic logic [DW-1:0] pat(input logic [ES-1:0] e);
      logic [DW-1:0] v;
      for (int i = 0; i < MW * MH; i++) v[i*ES +: ES] = e;
      return v;
   endfunction

   function automatic logic [DW-1:0] rnd_dw();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic set_req(input int r, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
      pend[r] = 1'b1;
      pa[r]   = a;
      pb[r]   = b;
   endtask

   task automatic maybe_new_req();
      for (int r = 0; r < 2; r++)
         if (spawn_en && !pend[r] && $urandom_range(0, 3) == 0)
            set_req(r, rnd_dw(), rnd_dw());
   endtask

   task automatic drive_reqs();
      bus.req0_valid = pend[0];
      bus.req0_a     = pa[0];
      bus.req0_b     = pb[0];
      bus.req1_valid = pend[1];
      bus.req1_a     = pa[1];
      bus.req1_b     = pb[1];
   endtask

   task automatic chk_busy(input string tag);
      chk({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
      chk({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive_reqs();
      bus.resp0_ready   = 1'b0;
      bus.resp1_ready   = 1'b0;
      bus.add_in_ready  = 1'b0;
      bus.add_out_valid = 1'b0;
      bus.add_out_data  = '0;
      #1;
      chk("rst_req0_ready", bus.req0_ready, 1'b0);
      chk("rst_req1_ready", bus.req1_ready, 1'b0);
      chk("rst_add_in_valid", bus.add_in_valid, 1'b0);
      chk("rst_add_out_ready", bus.add_out_ready, 1'b0);
      chk("rst_resp0_valid", bus.resp0_valid, 1'b0);
      chk("rst_resp1_valid", bus.resp1_valid, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_add_a", bus.add_a, '0);
      chk("rst_add_b", bus.add_b, '0);
      chk("rst_resp0_data", bus.resp0_data, '0);
      chk("rst_resp1_data", bus.resp1_data, '0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      mdl_rr  = 1'b0;
   endtask

   // mode 0: normal, 1: reset during WAIT, 2: adder never answers.
   task automatic serve_one(input int in_stall, input int wait_n,
                            input int resp_stall, input int mode);
      int            g;
      logic [DW-1:0] ea, eb, es;
      bit            deliver;
      // IDLE: grant cycle
      @(negedge clk);
      drive_reqs();
      bus.resp0_ready   = 1'b0;
      bus.resp1_ready   = 1'b0;
      bus.add_in_ready  = 1'($urandom_range(0, 1));
      bus.add_out_valid = 1'($urandom_range(0, 1));
      bus.add_out_data  = rnd_dw();
      #1;
      g = (pend[0] && pend[1]) ? int'(mdl_rr) : (pend[1] ? 1 : 0);
      chk("grant_req0_ready", bus.req0_ready, g == 0);
      chk("grant_req1_ready", bus.req1_ready, g == 1);
      chk("idle_add_in_valid", bus.add_in_valid, 1'b0);
      chk("idle_add_out_ready", bus.add_out_ready, 1'b0);
      ea      = pa[g];
      eb      = pb[g];
      es      = elem_sum(ea, eb);
      pend[g] = 1'b0;
      mdl_rr  = (g == 0);
      @(posedge clk);
      // ISSUE: spurious adder results must be ignored here
      for (int i = 0; i <= in_stall; i++) begin
         @(negedge clk);
         maybe_new_req();
         drive_reqs();
         bus.add_in_ready  = (i == in_stall);
         bus.add_out_valid = 1'($urandom_range(0, 1));
         bus.add_out_data  = rnd_dw();
         #1;
         chk("issue_add_in_valid", bus.add_in_valid, 1'b1);
         chk("issue_add_a", bus.add_a, ea);
         chk("issue_add_b", bus.add_b, eb);
         chk("issue_add_out_ready", bus.add_out_ready, 1'b0);
         chk_busy("issue");
         @(posedge clk);
      end
      // WAIT
      for (int i = 0; i <= wait_n; i++) begin
         @(negedge clk);
         if (mode == 1 && i == 1) begin
            reset_n = 1'b0;
            pend[0] = 1'b0;
            pend[1] = 1'b0;
            drive_reqs();
            bus.add_in_ready  = 1'b0;
            bus.add_out_valid = 1'b0;
            #1;
            chk("wrst_add_in_valid", bus.add_in_valid, 1'b0);
            chk("wrst_add_out_ready", bus.add_out_ready, 1'b0);
            chk("wrst_resp0_valid", bus.resp0_valid, 1'b0);
            chk("wrst_resp1_valid", bus.resp1_valid, 1'b0);
            chk("wrst_err", bus.err, 1'b0);
            chk("wrst_add_a", bus.add_a, '0);
            chk("wrst_add_b", bus.add_b, '0);
            chk("wrst_resp0_data", bus.resp0_data, '0);
            chk("wrst_resp1_data", bus.resp1_data, '0);
            @(posedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            mdl_rr  = 1'b0;
            bus.add_out_valid = 1'b1;
            bus.add_out_data  = es;
            #1;
            chk("late_add_out_ready", bus.add_out_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
            bus.add_out_valid = 1'b0;
            #1;
            chk("late_resp0_valid", bus.resp0_valid, 1'b0);
            chk("late_resp1_valid", bus.resp1_valid, 1'b0);
            chk("late_add_in_valid", bus.add_in_valid, 1'b0);
            return;
         end
         maybe_new_req();
         drive_reqs();
         bus.add_in_ready = 1'($urandom_range(0, 1));
`ifdef CMM_ARB_TIMEOUT_EN
         deliver = (mode != 2) && (i == wait_n);
`else
         deliver = (i == wait_n);
`endif
         bus.add_out_valid = deliver;
         bus.add_out_data  = deliver ? es : rnd_dw();
         #1;
         chk("wait_add_out_ready", bus.add_out_ready, 1'b1);
         chk("wait_add_in_valid", bus.add_in_valid, 1'b0);
         chk("wait_resp0_valid", bus.resp0_valid, 1'b0);
         chk("wait_resp1_valid", bus.resp1_valid, 1'b0);
`ifdef CMM_ARB_TIMEOUT_EN
         chk("wait_err", bus.err, (mode == 2) && (i == TMO - 1));
`else
         chk("wait_err", bus.err, 1'b0);
`endif
         chk_busy("wait");
         @(posedge clk);
      end
`ifdef CMM_ARB_TIMEOUT_EN
      if (mode == 2) begin
         @(negedge clk);
         bus.add_out_valid = 1'b0;
         #1;
         chk("tmo_add_out_ready", bus.add_out_ready, 1'b0);
         chk("tmo_err", bus.err, 1'b0);
         chk("tmo_resp0_valid", bus.resp0_valid, 1'b0);
         chk("tmo_resp1_valid", bus.resp1_valid, 1'b0);
         return;
      end
`endif
      // RESP
      for (int i = 0; i <= resp_stall; i++) begin
         @(negedge clk);
         maybe_new_req();
         drive_reqs();
         bus.add_out_valid = 1'($urandom_range(0, 1));
         bus.add_out_data  = rnd_dw();
         bus.resp0_ready   = (g == 0) ? (i == resp_stall)
                                      : 1'($urandom_range(0, 1));
         bus.resp1_ready   = (g == 1) ? (i == resp_stall)
                                      : 1'($urandom_range(0, 1));
         #1;
         chk("resp0_valid", bus.resp0_valid, g == 0);
         chk("resp1_valid", bus.resp1_valid, g == 1);
         last_resp = (g == 0) ? bus.resp0_data : bus.resp1_data;
         chk("resp_data", last_resp, es);
         chk("resp_add_out_ready", bus.add_out_ready, 1'b0);
         chk("resp_add_in_valid", bus.add_in_valid, 1'b0);
         chk_busy("resp");
         @(posedge clk);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      spawn_en = 1'b0;
      mdl_rr   = 1'b0;
      for (int r = 0; r < 2; r++) begin
         pend[r] = 1'b0;
         pa[r]   = '0;
         pb[r]   = '0;
      end
      do_reset();

      // lone requester 0, known operands, one-cycle adder
      set_req(0, pat(16'h0102), pat(16'h0304));
      serve_one(0, 0, 0, 0);
      chk("sum_0406", last_resp, pat(16'h0406));

      // simultaneous pair after reset, twice: grants 0,1,0,1
      do_reset();
      for (int k = 0; k < 2; k++) begin
         set_req(0, rnd_dw(), rnd_dw());
         set_req(1, rnd_dw(), rnd_dw());
         serve_one(0, 0, 0, 0);
         serve_one(0, 0, 0, 0);
      end

      // requester stalls response 10 cycles while the other waits
      set_req(0, rnd_dw(), rnd_dw());
      set_req(1, rnd_dw(), rnd_dw());
      serve_one(0, 0, 10, 0);
      serve_one(0, 0, 0, 0);

      // adder input stalled 5 cycles
      set_req(1, rnd_dw(), rnd_dw());
      serve_one(5, 1, 0, 0);

      // reset while waiting on the adder, then normal service
      set_req(1, rnd_dw(), rnd_dw());
      serve_one(0, 3, 0, 1);
      set_req(1, rnd_dw(), rnd_dw());
      serve_one(0, 0, 0, 0);

      // adder never answers (watchdog build) or answers very late
      set_req(0, rnd_dw(), rnd_dw());
`ifdef CMM_ARB_TIMEOUT_EN
      serve_one(0, TMO - 1, 0, 2);
`else
      serve_one(0, 80, 0, 2);
`endif
      set_req(0, rnd_dw(), rnd_dw());
      serve_one(0, 0, 0, 0);

      // random traffic
      spawn_en = 1'b1;
      for (int t = 0; t < 60; t++) begin
         if (!pend[0] && !pend[1]) begin
            case ($urandom_range(0, 2))
               0:       set_req(0, rnd_dw(), rnd_dw());
               1:       set_req(1, rnd_dw(), rnd_dw());
               default: begin
                  set_req(0, rnd_dw(), rnd_dw());
                  set_req(1, rnd_dw(), rnd_dw());
               end
            endcase
         end
         serve_one($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
